// File: rtl/inverse_phi1_stream.sv
// Inverse-phi1 balanced-ternary digit stream: LANES digits per beat, N digits per run,
// delivered on a registered valid/ready interface with lane mask, last flag and done pulse.
module inverse_phi1_stream #(
  parameter  int LANES = 4,
  parameter  int N     = 701,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         init,
  input  logic [LANES-1:0]   spe_case,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*LANES-1:0] digits,
  output logic [LANES-1:0]   lane_mask,
  output logic               last,
  output logic               done
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_fsm;
  state_t             w_fsm_next;
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_remaining;
  logic [2*LANES-1:0] r_digits;
  logic [LANES-1:0]   r_mask;
  logic               r_last;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;

  logic               w_gen;
  logic               w_finish;
  logic [1:0]         w_seed;
  logic [31:0]        w_rem_before;
  logic [1:0]         w_chain [LANES+1];
  logic [LANES-1:0]   w_real;
  logic [LANES-1:0]   w_is_tail;
  logic [2*LANES-1:0] w_beat;
  logic [1:0]         w_tail;
  logic               w_last_beat;
  logic [CNT_W-1:0]   w_rem_after;

  function automatic logic [1:0] step(input logic sc, input logic [1:0] s);
    logic g;
    g = ~(sc | s[1]);
    return {g & s[0], g | ~s[0]};
  endfunction

  // A fresh run seeds from init and counts all N digits; later beats continue from r_state.
  assign w_seed       = (r_fsm == S_IDLE) ? init : r_state;
  assign w_rem_before = (r_fsm == S_IDLE) ? 32'(N) : 32'(r_remaining);
  assign w_chain[0]   = w_seed;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_chain[gi+1]    = step(spe_case[gi], w_chain[gi]);
      assign w_real[gi]       = (w_rem_before > 32'(gi));
      assign w_beat[2*gi +: 2] = w_real[gi] ? w_chain[gi+1] : 2'b00;
      if (gi == LANES - 1) begin : g_top
        assign w_is_tail[gi] = w_real[gi];
      end else begin : g_mid
        assign w_is_tail[gi] = w_real[gi] & ~w_real[gi+1];
      end
    end
  endgenerate

  always_comb begin
    w_tail = 2'b00;
    for (int i = 0; i < LANES; i++) begin
      if (w_is_tail[i]) w_tail = w_chain[i+1];
    end
  end

  assign w_last_beat = (w_rem_before <= 32'(LANES));
  assign w_rem_after = w_last_beat ? '0 : CNT_W'(w_rem_before - 32'(LANES));

  always_ff @(posedge clk) begin
    if (!rst) r_fsm <= S_IDLE;
    else      r_fsm <= w_fsm_next;
  end

  // out_valid is always high while in RUN, so out_ready alone marks a handshake there.
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      S_IDLE:  if (start) w_fsm_next = S_RUN;
      S_RUN:   if (out_ready && (r_remaining == '0)) w_fsm_next = S_IDLE;
      default: w_fsm_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_gen    = 1'b0;
    w_finish = 1'b0;
    case (r_fsm)
      S_IDLE: w_gen = start;
      S_RUN: begin
        if (out_ready) begin
          if (r_remaining == '0) w_finish = 1'b1;
          else                   w_gen    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= 2'b00;
      r_remaining <= '0;
      r_digits    <= '0;
      r_mask      <= '0;
      r_last      <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_gen) begin
        r_digits    <= w_beat;
        r_mask      <= w_real;
        r_last      <= w_last_beat;
        r_state     <= w_tail;
        r_remaining <= w_rem_after;
        r_valid     <= 1'b1;
        r_busy      <= 1'b1;
      end else if (w_finish) begin
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign digits    = r_digits;
  assign lane_mask = r_mask;
  assign last      = r_last;
  assign done      = r_done;

endmodule

// File: tb/tb_inverse_phi1_stream.sv
// Scoreboard bench for inverse_phi1_stream: three instances (4x5, 4x8, 1x3) driven with
// directed runs; expected beats are queued at stimulus time and popped by per-instance monitors.
`timescale 1ns/1ps
module tb_inverse_phi1_stream;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] m;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_start, a_ready, a_busy, a_valid, a_last, a_done;
  logic [1:0] a_init;
  logic [3:0] a_spe, a_mask;
  logic [7:0] a_dig;

  logic       b_start, b_ready, b_busy, b_valid, b_last, b_done;
  logic [1:0] b_init;
  logic [3:0] b_spe, b_mask;
  logic [7:0] b_dig;

  logic       c_start, c_ready, c_busy, c_valid, c_last, c_done;
  logic [1:0] c_init;
  logic [0:0] c_spe, c_mask;
  logic [1:0] c_dig;

  beat_t qa[$];
  beat_t qb[$];
  beat_t qc[$];
  int n_cmp = 0;
  int n_bad = 0;

  inverse_phi1_stream #(.LANES(4), .N(5)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .init(a_init), .spe_case(a_spe),
    .busy(a_busy), .out_valid(a_valid), .out_ready(a_ready), .digits(a_dig),
    .lane_mask(a_mask), .last(a_last), .done(a_done));

  inverse_phi1_stream #(.LANES(4), .N(8)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .init(b_init), .spe_case(b_spe),
    .busy(b_busy), .out_valid(b_valid), .out_ready(b_ready), .digits(b_dig),
    .lane_mask(b_mask), .last(b_last), .done(b_done));

  inverse_phi1_stream #(.LANES(1), .N(3)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .init(c_init), .spe_case(c_spe),
    .busy(c_busy), .out_valid(c_valid), .out_ready(c_ready), .digits(c_dig),
    .lane_mask(c_mask), .last(c_last), .done(c_done));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input int id, input beat_t got);
    beat_t exp;
    int    sz;
    case (id)
      0:       sz = qa.size();
      1:       sz = qb.size();
      default: sz = qc.size();
    endcase
    if (sz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL inst%0d unexpected beat: got digits %h, expected none", id, got.d);
    end else begin
      case (id)
        0:       exp = qa.pop_front();
        1:       exp = qb.pop_front();
        default: exp = qc.pop_front();
      endcase
      $display("beat inst%0d digits=%h mask=%h last=%b", id, got.d, got.m, got.l);
      check($sformatf("inst%0d digits", id), 32'(got.d), 32'(exp.d));
      check($sformatf("inst%0d mask", id), 32'(got.m), 32'(exp.m));
      check($sformatf("inst%0d last", id), 32'(got.l), 32'(exp.l));
    end
  endtask

  always @(negedge clk) if (rst === 1'b1 && a_valid && a_ready) pop_cmp(0, beat_t'({a_dig, a_mask, a_last}));
  always @(negedge clk) if (rst === 1'b1 && b_valid && b_ready) pop_cmp(1, beat_t'({b_dig, b_mask, b_last}));
  always @(negedge clk) if (rst === 1'b1 && c_valid && c_ready)
    pop_cmp(2, beat_t'({6'b0, c_dig, 3'b0, c_mask, c_last}));

  function automatic logic done_of(input int id);
    case (id)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  function automatic logic valid_of(input int id);
    case (id)
      0:       return a_valid;
      1:       return b_valid;
      default: return c_valid;
    endcase
  endfunction

  function automatic logic busy_of(input int id);
    case (id)
      0:       return a_busy;
      1:       return b_busy;
      default: return c_busy;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int id, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = done_of(id);
    end
    check({name, " done seen"}, 32'(seen), 32'd1);
    check({name, " busy low at done"}, 32'(busy_of(id)), 32'd0);
    check({name, " valid low at done"}, 32'(valid_of(id)), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    a_start = 0; a_ready = 0; a_init = 0; a_spe = 0;
    b_start = 0; b_ready = 0; b_init = 0; b_spe = 0;
    c_start = 0; c_ready = 0; c_init = 0; c_spe = 0;
    tick();
    tick();
    check("reset a", {a_busy, a_valid, a_last, a_done, a_mask, a_dig}, 32'd0);
    check("reset b", {b_busy, b_valid, b_last, b_done, b_mask, b_dig}, 32'd0);
    check("reset c", {c_busy, c_valid, c_last, c_done, c_mask, c_dig}, 32'd0);
    rst = 1'b1;
    tick();

    // Basic run, N=5 over 4 lanes.
    qa.push_back('{8'h4D, 4'hF, 1'b0});
    qa.push_back('{8'h03, 4'h1, 1'b1});
    a_ready = 1; a_init = 2'b00; a_spe = 4'h0; a_start = 1;
    tick();
    a_start = 0;
    check("A valid after 1 clk", 32'(a_valid), 32'd1);
    check("A busy", 32'(a_busy), 32'd1);
    wait_done(0, "A");
    tick();
    check("A done single cycle", 32'(a_done), 32'd0);

    // Special-case lane 0 with init=+1.
    qa.push_back('{8'h34, 4'hF, 1'b0});
    qa.push_back('{8'h01, 4'h1, 1'b1});
    a_init = 2'b01; a_spe = 4'b0001; a_start = 1;
    tick();
    a_start = 0; a_spe = 4'h0;
    wait_done(0, "B1");

    // Backpressure: held beat, spe_case only matters in the release cycle.
    qa.push_back('{8'h4D, 4'hF, 1'b0});
    qa.push_back('{8'h00, 4'h1, 1'b1});
    a_ready = 0; a_init = 2'b00; a_spe = 4'h0; a_start = 1;
    tick();
    a_start = 0;
    for (int i = 0; i < 3; i++) begin
      a_spe = i[0] ? 4'h0 : 4'hE;
      tick();
      check("B2 hold digits", 32'(a_dig), 32'h4D);
      check("B2 hold mask", 32'(a_mask), 32'hF);
      check("B2 hold last", 32'(a_last), 32'd0);
      check("B2 hold valid", 32'(a_valid), 32'd1);
    end
    a_ready = 1; a_spe = 4'b0001;
    tick();
    a_spe = 4'h0;
    wait_done(0, "B2");

    // N=8: two full beats, start mid-run ignored.
    qb.push_back('{8'h4D, 4'hF, 1'b0});
    qb.push_back('{8'hD3, 4'hF, 1'b1});
    b_ready = 1; b_init = 2'b00; b_start = 1;
    tick();
    b_start = 1;
    tick();
    b_start = 0;
    wait_done(1, "C");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("C no extra beat", 32'(b_valid), 32'd0);
    end

    // Reset mid-run aborts without done.
    b_ready = 0; b_start = 1;
    tick();
    b_start = 0;
    tick();
    check("D running before reset", 32'(b_valid), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("D after reset", {b_busy, b_valid, b_last, b_done, b_mask, b_dig}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("D no done", 32'(b_done), 32'd0);
    end
    qb.push_back('{8'h4D, 4'hF, 1'b0});
    qb.push_back('{8'hD3, 4'hF, 1'b1});
    b_ready = 1; b_start = 1;
    tick();
    b_start = 0;
    wait_done(1, "D restart");

    // LANES=1, N=3, then restart in the done cycle.
    qc.push_back('{8'h01, 4'h1, 1'b0});
    qc.push_back('{8'h03, 4'h1, 1'b0});
    qc.push_back('{8'h00, 4'h1, 1'b1});
    c_ready = 1; c_init = 2'b00; c_spe = 1'b0; c_start = 1;
    tick();
    c_start = 0;
    wait_done(2, "E");
    qc.push_back('{8'h03, 4'h1, 1'b0});
    qc.push_back('{8'h00, 4'h1, 1'b0});
    qc.push_back('{8'h01, 4'h1, 1'b1});
    c_init = 2'b01; c_start = 1;
    tick();
    c_start = 0;
    check("E start in done cycle", 32'(c_busy), 32'd1);
    wait_done(2, "E2");

    tick();
    check("qa drained", 32'(qa.size()), 32'd0);
    check("qb drained", 32'(qb.size()), 32'd0);
    check("qc drained", 32'(qc.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
